// File: rtl/kfx86_shift_sequencer_pkg.sv
// Shared accumulator types, opcodes and the shift sequencer state encoding.
package kfx86_shift_sequencer_pkg;

  typedef struct packed {
    logic o;
    logic s;
    logic z;
    logic a;
    logic p;
    logic c;
  } flags_t;

  localparam logic [4:0] ALU_OP_ADD = 5'h00;
  localparam logic [4:0] ALU_OP_OR  = 5'h01;
  localparam logic [4:0] ALU_OP_ADC = 5'h02;
  localparam logic [4:0] ALU_OP_SBB = 5'h03;
  localparam logic [4:0] ALU_OP_AND = 5'h04;
  localparam logic [4:0] ALU_OP_SUB = 5'h05;
  localparam logic [4:0] ALU_OP_XOR = 5'h06;
  localparam logic [4:0] ALU_OP_CMP = 5'h07;
  localparam logic [4:0] ALU_OP_ROL = 5'h08;
  localparam logic [4:0] ALU_OP_ROR = 5'h09;
  localparam logic [4:0] ALU_OP_RCL = 5'h0A;
  localparam logic [4:0] ALU_OP_RCR = 5'h0B;
  localparam logic [4:0] ALU_OP_SHL = 5'h0C;
  localparam logic [4:0] ALU_OP_SHR = 5'h0D;
  localparam logic [4:0] ALU_OP_SAR = 5'h0E;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  function automatic logic is_shift_op(input logic [4:0] op);
    return op inside {ALU_OP_ROL, ALU_OP_ROR, ALU_OP_RCL, ALU_OP_RCR,
                      ALU_OP_SHL, ALU_OP_SHR, ALU_OP_SAR};
  endfunction

endpackage

// File: rtl/kfx86_shift_pack.sv
// Packs the work register into the 16-bit accumulator input and unpacks the
// single-bit shift response; byte operands are placed so the 16-bit shift
// yields the byte result in one lane.
module kfx86_shift_pack
  import kfx86_shift_sequencer_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic        select_word,
  input  logic [15:0] work,
  input  logic        carry,
  input  logic [15:0] alu_out,
  input  flags_t      alu_out_flags,
  output logic [15:0] source_1,
  output logic [15:0] next_work,
  output flags_t      next_flags
);

  logic [7:0] b;
  logic [7:0] new_b;
  logic       high_lane;

  assign b = work[7:0];

  // Byte placement inside the 16-bit source and which lane holds the answer.
  always_comb begin
    source_1  = work;
    high_lane = 1'b0;
    if (!select_word) begin
      unique case (opcode)
        ALU_OP_ROL, ALU_OP_ROR: begin
          source_1  = {b, b};
          high_lane = 1'b1;
        end
        ALU_OP_RCL: begin
          source_1  = {b, carry, 7'b0};
          high_lane = 1'b1;
        end
        ALU_OP_SHL: begin
          source_1  = {b, 8'h00};
          high_lane = 1'b1;
        end
        ALU_OP_RCR: source_1 = {7'b0, carry, b};
        ALU_OP_SAR: source_1 = {{8{b[7]}}, b};
        default:    source_1 = {8'h00, b};
      endcase
    end
  end

  // Unpack the chosen lane; right shifts into the low lane see the wrong
  // top bits for O, so O is recomputed from the byte result.
  always_comb begin
    new_b      = high_lane ? alu_out[15:8] : alu_out[7:0];
    next_work  = select_word ? alu_out : {8'h00, new_b};
    next_flags = alu_out_flags;
    if (!select_word && (opcode == ALU_OP_RCR || opcode == ALU_OP_SHR)) begin
      next_flags.o = new_b[7] ^ new_b[6];
    end
  end

endmodule

// File: rtl/kfx86_shift_sequencer.sv
// Iterates the shared accumulator's single-bit shift/rotate ops for a count,
// holding the partial value, flags and remaining count between iterations.
module kfx86_shift_sequencer
  import kfx86_shift_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [15:0] operand,
  input  logic [7:0]  count,
  input  logic        select_word,
  input  flags_t      flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output flags_t      result_flags,
  output logic [4:0]  alu_opcode,
  output logic [15:0] alu_source_1,
  output logic [15:0] alu_source_2,
  output flags_t      alu_source_flags,
  output logic        alu_select_word,
  input  logic [15:0] alu_out,
  input  flags_t      alu_out_flags
);

  seq_state_t  state, state_d;
  logic [4:0]  op_q, op_d;
  logic        word_q, word_d;
  logic [15:0] work_q, work_d;
  flags_t      flags_q, flags_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] step_work;
  flags_t      step_flags;

  kfx86_shift_pack u_pack (
    .opcode        (op_q),
    .select_word   (word_q),
    .work          (work_q),
    .carry         (flags_q.c),
    .alu_out       (alu_out),
    .alu_out_flags (alu_out_flags),
    .source_1      (alu_source_1),
    .next_work     (step_work),
    .next_flags    (step_flags)
  );

  assign alu_opcode       = op_q;
  assign alu_source_2     = '0;
  assign alu_source_flags = flags_q;
  assign alu_select_word  = word_q;

  // Next-state and datapath update: latch on accepted start, step once per RUN cycle.
  always_comb begin
    state_d = state;
    op_d    = op_q;
    word_d  = word_q;
    work_d  = work_q;
    flags_d = flags_q;
    count_d = count_q;
    unique case (state)
      SEQ_IDLE: begin
        if (start) begin
          op_d    = opcode;
          word_d  = select_word;
          work_d  = operand;
          flags_d = flags_in;
          count_d = count;
          state_d = (count == 8'd0 || !is_shift_op(opcode)) ? SEQ_DONE : SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        work_d  = step_work;
        flags_d = step_flags;
        count_d = count_q - 8'd1;
        if (count_q == 8'd1) state_d = SEQ_DONE;
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  // State, work registers and registered outputs; result loads on entry to DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= SEQ_IDLE;
      op_q         <= '0;
      word_q       <= 1'b0;
      work_q       <= '0;
      flags_q      <= '0;
      count_q      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      result_flags <= '0;
    end else begin
      state   <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      work_q  <= work_d;
      flags_q <= flags_d;
      count_q <= count_d;
      busy    <= (state_d != SEQ_IDLE);
      done    <= (state_d == SEQ_DONE);
      if (state_d == SEQ_DONE) begin
        result       <= word_d ? work_d : {8'h00, work_d[7:0]};
        result_flags <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_kfx86_shift_sequencer.sv
// Bench for kfx86_shift_sequencer: a 16-bit accumulator model answers the
// alu_* drive, a width-aware reference computes expected results, and a
// scoreboard checks each done pulse.
module tb_kfx86_shift_sequencer;
  import kfx86_shift_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [15:0] operand = '0;
  logic [7:0]  count = '0;
  logic        select_word = 1'b0;
  flags_t      flags_in = '0;
  logic        busy, done;
  logic [15:0] result;
  flags_t      result_flags;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_source_1, alu_source_2, alu_out;
  flags_t      alu_source_flags, alu_out_flags;
  logic        alu_select_word;

  kfx86_shift_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .opcode           (opcode),
    .operand          (operand),
    .count            (count),
    .select_word      (select_word),
    .flags_in         (flags_in),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .result_flags     (result_flags),
    .alu_opcode       (alu_opcode),
    .alu_source_1     (alu_source_1),
    .alu_source_2     (alu_source_2),
    .alu_source_flags (alu_source_flags),
    .alu_select_word  (alu_select_word),
    .alu_out          (alu_out),
    .alu_out_flags    (alu_out_flags)
  );

  always #5 clock = ~clock;

  // 16-bit single-bit shift accumulator model.
  always_comb begin
    alu_out       = alu_source_1;
    alu_out_flags = alu_source_flags;
    case (alu_opcode)
      ALU_OP_ROL: begin
        alu_out = {alu_source_1[14:0], alu_source_1[15]};
        alu_out_flags.c = alu_source_1[15];
        alu_out_flags.o = alu_source_1[14] ^ alu_source_1[15];
      end
      ALU_OP_ROR: begin
        alu_out = {alu_source_1[0], alu_source_1[15:1]};
        alu_out_flags.c = alu_source_1[0];
        alu_out_flags.o = alu_source_1[0] ^ alu_source_1[15];
      end
      ALU_OP_RCL: begin
        alu_out = {alu_source_1[14:0], alu_source_flags.c};
        alu_out_flags.c = alu_source_1[15];
        alu_out_flags.o = alu_source_1[14] ^ alu_source_1[15];
      end
      ALU_OP_RCR: begin
        alu_out = {alu_source_flags.c, alu_source_1[15:1]};
        alu_out_flags.c = alu_source_1[0];
        alu_out_flags.o = alu_source_flags.c ^ alu_source_1[15];
      end
      ALU_OP_SHL: begin
        alu_out = {alu_source_1[14:0], 1'b0};
        alu_out_flags.c = alu_source_1[15];
        alu_out_flags.o = alu_source_1[14] ^ alu_source_1[15];
        alu_out_flags.s = alu_source_1[14];
        alu_out_flags.z = (alu_source_1[14:0] == 15'd0);
      end
      ALU_OP_SHR: begin
        alu_out = {1'b0, alu_source_1[15:1]};
        alu_out_flags.c = alu_source_1[0];
        alu_out_flags.o = alu_source_1[15];
        alu_out_flags.s = 1'b0;
        alu_out_flags.z = (alu_source_1[15:1] == 15'd0);
      end
      ALU_OP_SAR: begin
        alu_out = {alu_source_1[15], alu_source_1[15:1]};
        alu_out_flags.c = alu_source_1[0];
        alu_out_flags.o = 1'b0;
        alu_out_flags.s = alu_source_1[15];
        alu_out_flags.z = (alu_source_1[15:1] == 15'd0);
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [4:0]  op;
    logic [15:0] operand;
    logic [7:0]  cnt;
    logic        word;
    flags_t      fl;
    logic [15:0] exp_result;
    logic        exp_c;
    int unsigned pulse;
  } vec_t;

  typedef struct {
    logic [15:0] result;
    flags_t      fl;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[12];
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // x86 shift semantics at the operand width, one bit per iteration.
  task automatic ref_model(input vec_t v, output logic [15:0] r, output flags_t f);
    int unsigned w;
    logic [15:0] val, mask;
    logic msb, lsb, cin;
    w    = v.word ? 16 : 8;
    mask = v.word ? 16'hFFFF : 16'h00FF;
    val  = v.operand & mask;
    f    = v.fl;
    if (is_shift_op(v.op)) begin
      for (int unsigned i = 0; i < 32'(v.cnt); i++) begin
        msb = val[w-1];
        lsb = val[0];
        cin = f.c;
        case (v.op)
          ALU_OP_ROL: begin val = ((val << 1) | 16'(msb)) & mask; f.c = msb; end
          ALU_OP_ROR: begin val = (val >> 1) | (16'(lsb) << (w-1)); f.c = lsb; end
          ALU_OP_RCL: begin val = ((val << 1) | 16'(cin)) & mask; f.c = msb; end
          ALU_OP_RCR: begin val = (val >> 1) | (16'(cin) << (w-1)); f.c = lsb; end
          ALU_OP_SHL: begin val = (val << 1) & mask; f.c = msb; end
          ALU_OP_SHR: begin val = val >> 1; f.c = lsb; end
          default:    begin val = (val >> 1) | (16'(msb) << (w-1)); f.c = lsb; end
        endcase
        if (v.op inside {ALU_OP_ROL, ALU_OP_RCL, ALU_OP_SHL}) f.o = val[w-1] ^ f.c;
        else f.o = val[w-1] ^ val[w-2];
        if (v.op inside {ALU_OP_SHL, ALU_OP_SHR, ALU_OP_SAR}) begin
          f.s = val[w-1];
          f.z = (val == 16'd0);
        end
      end
    end
    r = val;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding job.
  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      check("done_has_job", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.result));
        check("result_flags", 32'(result_flags), 32'(e.fl));
        check("carry", 32'(result_flags.c), 32'(e.c));
      end
    end
  end

  task automatic run_job(input vec_t v);
    exp_t        e;
    logic [15:0] mr;
    flags_t      mf;
    int unsigned lat, cyc;
    @(negedge clock);
    check("idle_busy", 32'(busy), 0);
    ref_model(v, mr, mf);
    e.result = v.exp_result;
    e.fl     = mf;
    e.c      = v.exp_c;
    sb.push_back(e);
    lat = (v.cnt == 8'd0 || !is_shift_op(v.op)) ? 1 : 32'(v.cnt) + 1;
    opcode = v.op; operand = v.operand; count = v.cnt;
    select_word = v.word; flags_in = v.fl; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    check("alu_source_2", 32'(alu_source_2), 0);
    check("alu_opcode", 32'(alu_opcode), 32'(v.op));
    check("alu_select_word", 32'(alu_select_word), 32'(v.word));
    while (!done && cyc < 300) begin
      check("busy_run", 32'(busy), 1);
      if (cyc == v.pulse) begin
        start = 1'b1; operand = ~v.operand; count = 8'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 1);
    check("latency", cyc, lat);
    check("busy_at_done", 32'(busy), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    logic [15:0] mr;
    flags_t mf;

    vecs[0]  = '{ALU_OP_SHL, 16'h8001, 8'd1,   1'b1, flags_t'(6'h00), 16'h0002, 1'b1, 0};
    vecs[1]  = '{ALU_OP_ROR, 16'h0001, 8'd3,   1'b0, flags_t'(6'h00), 16'h0020, 1'b0, 0};
    vecs[2]  = '{ALU_OP_RCL, 16'h0080, 8'd9,   1'b0, flags_t'(6'h00), 16'h0080, 1'b0, 0};
    vecs[3]  = '{ALU_OP_SAR, 16'h0081, 8'd2,   1'b0, flags_t'(6'h00), 16'h00E0, 1'b0, 0};
    vecs[4]  = '{ALU_OP_SHR, 16'h1234, 8'd0,   1'b1, flags_t'(6'h01), 16'h1234, 1'b1, 0};
    vecs[5]  = '{ALU_OP_SHR, 16'h0081, 8'd1,   1'b0, flags_t'(6'h00), 16'h0040, 1'b1, 0};
    vecs[6]  = '{ALU_OP_ADD, 16'hBEEF, 8'd5,   1'b1, flags_t'(6'h0D), 16'hBEEF, 1'b1, 0};
    vecs[7]  = '{ALU_OP_SHL, 16'hAB55, 8'd0,   1'b0, flags_t'(6'h01), 16'h0055, 1'b1, 0};
    vecs[8]  = '{ALU_OP_RCR, 16'h0001, 8'd4,   1'b1, flags_t'(6'h00), 16'h2000, 1'b0, 2};
    vecs[9]  = '{ALU_OP_ROL, 16'hFF96, 8'd2,   1'b0, flags_t'(6'h06), 16'h005A, 1'b0, 0};
    vecs[10] = '{ALU_OP_ROL, 16'h8000, 8'd255, 1'b1, flags_t'(6'h00), 16'h4000, 1'b0, 0};
    vecs[11] = '{ALU_OP_RCR, 16'h0001, 8'd1,   1'b0, flags_t'(6'h01), 16'h0080, 1'b1, 0};

    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", 32'(result), 0);
    check("reset_flags", 32'(result_flags), 0);
    reset = 1'b0;

    foreach (vecs[i]) run_job(vecs[i]);

    // Reset in cycle 3 of a count-10 job: abandoned, no done afterwards.
    @(negedge clock);
    opcode = ALU_OP_SHL; operand = 16'h00FF; count = 8'd10;
    select_word = 1'b1; flags_in = flags_t'(6'h3F); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrun_reset_busy", 32'(busy), 0);
    check("midrun_reset_done", 32'(done), 0);
    check("midrun_reset_result", 32'(result), 0);
    check("midrun_reset_flags", 32'(result_flags), 0);
    check("midrun_reset_alu_src", 32'(alu_source_1), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check("no_done_after_reset", 32'(done), 0);
    check("idle_after_reset", 32'(busy), 0);
    run_job(vecs[0]);

    // Random jobs checked against the reference alone.
    for (int k = 0; k < 8; k++) begin
      rv.op      = ALU_OP_ROL + 5'($urandom_range(0, 6));
      rv.operand = 16'($urandom);
      rv.cnt     = 8'($urandom_range(0, 20));
      rv.word    = 1'($urandom_range(0, 1));
      rv.fl      = flags_t'(6'($urandom));
      rv.pulse   = 0;
      ref_model(rv, mr, mf);
      rv.exp_result = mr;
      rv.exp_c      = mf.c;
      run_job(rv);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/kfx86_shift_sequencer.md
# kfx86_shift_sequencer

Multi-cycle controller that runs the accumulator's single-bit shift/rotate operations (ROL, ROR, RCL, RCR, SHL, SHR, SAR) for an iteration count. It serves x86 "shift r/m, CL" forms. The execution unit hands it an operand, opcode, count and flags, then waits for `done`. Each iteration drives the shared accumulator once, with byte-operand packing and correction applied, and registers the partial result and flags.

## Interface
Parameters: none.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request pulse; sampled only in IDLE
- opcode  in  5  shift-group ALU opcode (ALU_OP_ROL..ALU_OP_SAR)
- operand  in  16  value to shift; byte ops use [7:0]
- count  in  8  iteration count (CL or 1), unmasked, 0..255
- select_word  in  1  1 = 16-bit, 0 = 8-bit
- flags_in  in  flags_t  flags at start
- busy  out  1  high from accepted start until `done` cycle inclusive
- done  out  1  one-cycle completion pulse
- result  out  16  final value; byte ops zero-extended
- result_flags  out  flags_t  final flags
- alu_opcode / alu_source_1 / alu_source_2 / alu_source_flags / alu_select_word  out  5/16/16/flags_t/1  accumulator drive
- alu_out / alu_out_flags  in  16/flags_t  accumulator response

## Operation
- **States:** IDLE, RUN, DONE (encoding in package).
- **IDLE, start=1:**
  - Latch opcode and select_word.
  - Latch W (work register) = operand, F = flags_in, N = count.
  - If N==0 or opcode is not a shift opcode: go to DONE with W and F unchanged.
  - Otherwise: go to RUN.
- **IDLE, start=0:** stay in IDLE.
- **RUN, each cycle:**
  - Drive alu_opcode = latched opcode, alu_source_2 = 0, alu_source_flags = F, alu_select_word = latched select_word.
  - Drive alu_source_1 from the packing rule below.
  - On the clock edge: W ← unpacked alu_out, F ← alu_out_flags (with correction), N ← N−1.
  - When N==1, go to DONE after this update.
- **DONE:** `done`=1 for one cycle; result = zero-extended W, result_flags = F; next state IDLE.
- start is ignored in RUN and DONE; no queueing.
- **Word mode:** alu_source_1 = W, W ← alu_out.
- **Byte packing** (b = W[7:0], c = F.c):
  - ROL/ROR: {b,b}; take alu_out[15:8].
  - RCL: {b,c,7'b0}; take [15:8].
  - SHL: {b,8'h00}; take [15:8].
  - RCR: {7'b0,c,b}; take [7:0].
  - SHR: {8'h00,b}; take [7:0].
  - SAR: {{8{b[7]}},b}; take [7:0].
- **Byte correction:** for RCR/SHR, F.o ← new_b[7]^new_b[6]. All other flags come from alu_out_flags unmodified.
- **Reset:** can occur mid-RUN; returns to IDLE, abandons the operation, and drives all outputs to reset values.
- **Reset values:** busy 0, done 0, result 16'h0000, result_flags all 0, internal W/N/F 0.
- **ALU drive outside RUN:** alu_* ports are driven from the latched registers (deterministic, not X), and their response is ignored.

## Timing
- result, result_flags, done and busy are registered. alu_* drive is combinational from state and latched registers.
- Count N ≥ 1: start sampled at edge 0, RUN occupies cycles 1..N, done high in cycle N+1.
- Count 0 or non-shift opcode: done high in cycle 1.
- Maximum occupancy: 257 cycles (N=255).
- Back-to-back: start may be asserted in the cycle after `done` (IDLE), giving one idle cycle minimum between jobs.
- result and result_flags hold after `done` until the next DONE cycle updates them.

## Structure
- Reuse flags_t and the ALU_OP_* opcode constants from the shared accumulator header.
- Add to the shared package:
  - sequencer state enum (IDLE/RUN/DONE)
  - an `is_shift_op` function covering the seven shift opcodes.
- One natural sub-module, kfx86_shift_pack: a combinational byte/word pack of W into alu_source_1, plus unpack of alu_out and the O-flag correction.
- The top holds the FSM, counter and registers and instantiates no accumulator; it connects to the shared one through the alu_* ports.

## Test plan
- **Word SHL:** operand 16'h8001, count 1 → result 16'h0002, C=1, O=1; done in cycle 2; busy high cycles 1–2.
- **Byte ROR:** operand 8'h01, count 3 → result 16'h0020, C=0; done in cycle 4; W sequence 80,40,20.
- **Byte RCL:** operand 8'h80, C=0, count 9 → result 16'h0080, C=0 (full 9-bit loop). **Byte SAR:** 8'h81, count 2 → 16'h00E0, C=0, S=1, Z=0.
- **Count 0:** word SHR, 16'h1234, flags_in C=1 → result 16'h1234, flags equal flags_in, done in cycle 1. **Byte SHR:** 8'h81, count 1 → 16'h0040, C=1, O=1.
- **Word RCR, start pulsed while busy:**
  - Setup: operand 16'h0001, C=0, count 4.
  - Pulse start again in cycle 2 → ignored; one done only; result 16'h2000, C=0.
  - Immediate restart in the cycle after done is accepted.
- **Reset mid-operation:**
  - Assert reset in cycle 3 of a count-10 job → busy/done/result/result_flags return to 0 asynchronously.
  - No done pulse follows.
  - The next start runs normally.
